// File: rtl/mem_beat_gen_pkg.sv
// Shared types for the burst-to-beat address generator.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: burst encodings, beat length/size widths, burst command struct,
// FSM state encoding, and a helper that recognises wrappable burst lengths.
package mem_beat_gen_pkg;

    localparam int LenWidth  = 8;
    localparam int SizeWidth = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Per-burst control captured at command acceptance (size already clamped).
    typedef struct packed {
        burst_e                 burst;
        logic [LenWidth-1:0]    len;
        logic [SizeWidth-1:0]   size;
    } burst_cmd_t;

    // Only power-of-two beat counts 2/4/8/16 form a wrap container.
    function automatic logic is_wrap_len(input logic [LenWidth-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/mem_beat_addr_next.sv
// Next beat address from the current beat address (combinational).
// Latency: 0 cycles.
// Backpressure: none, pure function of its inputs.
// Ports: i_addr current beat address, i_size clamped log2 beat bytes,
//        i_burst burst type, i_len beats minus one, i_lower wrap lower bound,
//        o_next address of the following beat.
// Config: MEM_BEAT_GEN_WRAP_EN enables wrap-at-container handling; otherwise
//         WRAP follows the INCR path and i_lower/i_len are ignored.
module mem_beat_addr_next
    import mem_beat_gen_pkg::*;
#(
    parameter int AddrWidth = 32
) (
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [SizeWidth-1:0] i_size,
    input  burst_e               i_burst,
    input  logic [LenWidth-1:0]  i_len,
    input  logic [AddrWidth-1:0] i_lower,
    output logic [AddrWidth-1:0] o_next
);

    logic [AddrWidth-1:0] w_step;
    logic [AddrWidth-1:0] w_aligned;
    logic [AddrWidth-1:0] w_incr;

    assign w_step    = AddrWidth'(1) << i_size;
    // Beat 0 may be unaligned; every later beat lands on a size boundary.
    assign w_aligned = i_addr & ~(w_step - AddrWidth'(1));
    assign w_incr    = w_aligned + w_step;

`ifdef MEM_BEAT_GEN_WRAP_EN
    logic [AddrWidth-1:0] w_container;
    logic [AddrWidth-1:0] w_bound;
    logic                 w_wrap;

    assign w_container = AddrWidth'({1'b0, i_len} + 9'd1) << i_size;
    assign w_bound     = i_lower + w_container;
    assign w_wrap      = (i_burst == BURST_WRAP) && is_wrap_len(i_len);

    always_comb begin
        o_next = w_incr;
        if (i_burst == BURST_FIXED) begin
            o_next = i_addr;
        end else if (w_wrap && (w_incr == w_bound)) begin
            o_next = i_lower;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_lower, i_len};

    always_comb begin
        o_next = w_incr;
        if (i_burst == BURST_FIXED) begin
            o_next = i_addr;
        end
    end
`endif

endmodule

// File: rtl/mem_beat_gen.sv
// Expands a burst command into per-beat byte addresses with index/last/id.
// Latency: beat 0 one cycle after command handshake; back-to-back bursts gapless.
// Backpressure: beat outputs hold while beat_valid_o & !beat_ready_i; cmd_ready_o
//               only in IDLE or on the final beat's handshake; flush_i drops all.
// Ports: clk_i/rst_ni (sync, active-low), flush_i, cmd_* command channel,
//        beat_* per-beat request channel, busy_o.
// Config: MEM_BEAT_GEN_WRAP_EN adds WRAP burst support (default: WRAP as INCR).
module mem_beat_gen
    import mem_beat_gen_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [7:0]           cmd_len_i,
    input  logic [2:0]           cmd_size_i,
    input  logic [1:0]           cmd_burst_i,
    input  logic [IdWidth-1:0]   cmd_id_i,
    output logic                 beat_valid_o,
    input  logic                 beat_ready_i,
    output logic [AddrWidth-1:0] beat_addr_o,
    output logic [IdWidth-1:0]   beat_id_o,
    output logic [7:0]           beat_idx_o,
    output logic                 beat_last_o,
    output logic                 busy_o
);

    localparam logic [SizeWidth-1:0] MaxSize = SizeWidth'($clog2(DataWidth / 8));

    state_e               r_state, w_state_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [AddrWidth-1:0] r_addr,  w_addr_nxt;
    logic [IdWidth-1:0]   r_id,    w_id_nxt;
    logic [7:0]           r_idx,   w_idx_nxt;
    logic                 r_last,  w_last_nxt;
    burst_cmd_t           r_cmd,   w_cmd_nxt;

    logic [SizeWidth-1:0] w_size;
    logic                 w_beat_hs;
    logic                 w_accept;
    logic [AddrWidth-1:0] w_addr_next;
    logic [AddrWidth-1:0] w_lower;
    logic [7:0]           w_idx_inc;

    assign w_size    = (cmd_size_i > MaxSize) ? MaxSize : cmd_size_i;
    assign w_beat_hs = r_valid & beat_ready_i;
    assign w_idx_inc = r_idx + 8'd1;

    // rst_ni is folded in so no command is taken while reset is asserted.
    assign cmd_ready_o = rst_ni & ~flush_i &
                         ((r_state == ST_IDLE) | ((r_state == ST_BURST) & w_beat_hs & r_last));
    assign w_accept    = cmd_valid_i & cmd_ready_o;

`ifdef MEM_BEAT_GEN_WRAP_EN
    logic [AddrWidth-1:0] r_lower;
    logic [AddrWidth-1:0] w_container_ld;

    assign w_container_ld = AddrWidth'({1'b0, cmd_len_i} + 9'd1) << w_size;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lower <= '0;
        end else if (w_accept) begin
            r_lower <= cmd_addr_i & ~(w_container_ld - AddrWidth'(1));
        end
    end

    assign w_lower = r_lower;
`else
    assign w_lower = '0;
`endif

    mem_beat_addr_next #(
        .AddrWidth (AddrWidth)
    ) u_addr_next (
        .i_addr  (r_addr),
        .i_size  (r_cmd.size),
        .i_burst (r_cmd.burst),
        .i_len   (r_cmd.len),
        .i_lower (w_lower),
        .o_next  (w_addr_next)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_id    <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_id    <= w_id_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_cmd   <= w_cmd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_id_nxt    = r_id;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_cmd_nxt   = r_cmd;

        if (flush_i) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
        end else if (w_accept) begin
            // Covers both IDLE start and gapless follow-on after a last beat.
            w_state_nxt     = ST_BURST;
            w_valid_nxt     = 1'b1;
            w_addr_nxt      = cmd_addr_i;
            w_id_nxt        = cmd_id_i;
            w_idx_nxt       = 8'd0;
            w_last_nxt      = (cmd_len_i == 8'd0);
            w_cmd_nxt.burst = burst_e'(cmd_burst_i);
            w_cmd_nxt.len   = cmd_len_i;
            w_cmd_nxt.size  = w_size;
        end else if ((r_state == ST_BURST) && w_beat_hs) begin
            if (r_last) begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end else begin
                w_addr_nxt = w_addr_next;
                w_idx_nxt  = w_idx_inc;
                w_last_nxt = (w_idx_inc == r_cmd.len);
            end
        end
    end

    assign beat_valid_o = r_valid;
    assign beat_addr_o  = r_addr;
    assign beat_id_o    = r_id;
    assign beat_idx_o   = r_idx;
    assign beat_last_o  = r_last;
    assign busy_o       = (r_state == ST_BURST);

endmodule

// File: tb/tb_mem_beat_gen.sv
// Directed bench for mem_beat_gen: table of single bursts plus hand-written
// stall / back-to-back / flush / reset sequences.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mem_beat_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_id;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic [3:0]  beat_id;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_beat_gen #(
        .AddrWidth (32),
        .DataWidth (64),
        .IdWidth   (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .cmd_size_i   (cmd_size),
        .cmd_burst_i  (cmd_burst),
        .cmd_id_i     (cmd_id),
        .beat_valid_o (beat_valid),
        .beat_ready_i (beat_ready),
        .beat_addr_o  (beat_addr),
        .beat_id_o    (beat_id),
        .beat_idx_o   (beat_idx),
        .beat_last_o  (beat_last),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [2:0]       nb;
        logic [3:0][31:0] exp;   // exp[0] is beat 0
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [3:0] id);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        cmd_id    = id;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [7:0] idx,
                              input logic last, input logic [3:0] id);
        check({tag, " valid"}, 32'(beat_valid), 32'd1);
        check({tag, " addr"},  beat_addr, a);
        check({tag, " idx"},   32'(beat_idx), 32'(idx));
        check({tag, " last"},  32'(beat_last), 32'(last));
        check({tag, " id"},    32'(beat_id), 32'(id));
    endtask

    task automatic run_vec(input vec_t v, input int k);
        string tag;
        @(negedge clk);
        drive_cmd(v.addr, v.len, v.size, v.burst, k[3:0]);
        check($sformatf("v%0d cmd_ready", k), 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int b = 0; b < int'(v.nb); b++) begin
            tag = $sformatf("v%0d b%0d", k, b);
            check_beat(tag, v.exp[b], 8'(b), b == int'(v.nb) - 1, k[3:0]);
            @(negedge clk);
        end
        check($sformatf("v%0d idle valid", k), 32'(beat_valid), 32'd0);
        check($sformatf("v%0d idle busy", k), 32'(busy), 32'd0);
    endtask

    initial begin
        // addr, len, size, burst, beats, {beat3, beat2, beat1, beat0}
        vecs[0] = '{32'h1004, 8'd3, 3'd2, 2'b01, 3'd4, {32'h1010, 32'h100C, 32'h1008, 32'h1004}};
        vecs[1] = '{32'h1003, 8'd1, 3'd3, 2'b01, 3'd2, {32'h0, 32'h0, 32'h1008, 32'h1003}};
        vecs[2] = '{32'h1003, 8'd1, 3'd4, 2'b01, 3'd2, {32'h0, 32'h0, 32'h1008, 32'h1003}};
`ifdef MEM_BEAT_GEN_WRAP_EN
        vecs[3] = '{32'h1018, 8'd3, 3'd3, 2'b10, 3'd4, {32'h1010, 32'h1008, 32'h1000, 32'h1018}};
`else
        vecs[3] = '{32'h1018, 8'd3, 3'd3, 2'b10, 3'd4, {32'h1030, 32'h1028, 32'h1020, 32'h1018}};
`endif
        vecs[4] = '{32'h2005, 8'd2, 3'd1, 2'b00, 3'd3, {32'h0, 32'h2005, 32'h2005, 32'h2005}};
        vecs[5] = '{32'h3001, 8'd1, 3'd0, 2'b11, 3'd2, {32'h0, 32'h0, 32'h3002, 32'h3001}};
        vecs[6] = '{32'hFFFFFFF8, 8'd1, 3'd3, 2'b01, 3'd2, {32'h0, 32'h0, 32'h0, 32'hFFFFFFF8}};
        vecs[7] = '{32'h0040, 8'd0, 3'd2, 2'b01, 3'd1, {32'h0, 32'h0, 32'h0, 32'h0040}};
        // len 2 is not a wrap length: INCR in every build
        vecs[8] = '{32'h1018, 8'd2, 3'd3, 2'b10, 3'd3, {32'h0, 32'h1028, 32'h1020, 32'h1018}};

        rst_n      = 1'b0;
        flush      = 1'b1;
        beat_ready = 1'b1;
        drive_cmd(32'hDEAD, 8'd3, 3'd2, 2'b01, 4'hF);

        // Reset state, with command and flush active during reset
        repeat (2) @(negedge clk);
        check("rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst valid", 32'(beat_valid), 32'd0);
        check("rst addr", beat_addr, 32'd0);
        check("rst id", 32'(beat_id), 32'd0);
        check("rst idx", 32'(beat_idx), 32'd0);
        check("rst last", 32'(beat_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        cmd_valid = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b1;

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], k);
        end

        // Stall on beat 1, then a second command held during the last beat
        @(negedge clk);
        drive_cmd(32'h0100, 8'd3, 3'd2, 2'b01, 4'd5);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_beat("st b0", 32'h0100, 8'd0, 1'b0, 4'd5);
        @(negedge clk);
        beat_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("stall%0d", i), 32'h0104, 8'd1, 1'b0, 4'd5);
            @(negedge clk);
        end
        beat_ready = 1'b1;
        check_beat("st b1", 32'h0104, 8'd1, 1'b0, 4'd5);
        @(negedge clk);
        check_beat("st b2", 32'h0108, 8'd2, 1'b0, 4'd5);
        @(negedge clk);
        check_beat("st b3", 32'h010C, 8'd3, 1'b1, 4'd5);
        drive_cmd(32'h0500, 8'd0, 3'd2, 2'b01, 4'd9);
        check("b2b cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_beat("b2b b0", 32'h0500, 8'd0, 1'b1, 4'd9);
        check("b2b busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b end valid", 32'(beat_valid), 32'd0);

        // Flush on beat 2 of a len-7 burst with a concurrent command
        drive_cmd(32'h0800, 8'd7, 3'd2, 2'b01, 4'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_beat("fl b0", 32'h0800, 8'd0, 1'b0, 4'd3);
        @(negedge clk);
        @(negedge clk);
        check_beat("fl b2", 32'h0808, 8'd2, 1'b0, 4'd3);
        flush = 1'b1;
        drive_cmd(32'h0900, 8'd1, 3'd2, 2'b01, 4'd7);
        check("fl cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        check("fl valid", 32'(beat_valid), 32'd0);
        check("fl busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("fl still idle", 32'(beat_valid), 32'd0);
        drive_cmd(32'h0900, 8'd1, 3'd2, 2'b01, 4'd7);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_beat("pf b0", 32'h0900, 8'd0, 1'b0, 4'd7);
        @(negedge clk);
        check_beat("pf b1", 32'h0904, 8'd1, 1'b1, 4'd7);
        @(negedge clk);

        // Reset mid-burst
        drive_cmd(32'h0C00, 8'd7, 3'd3, 2'b01, 4'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_beat("mr b1", 32'h0C08, 8'd1, 1'b0, 4'd2);
        rst_n = 1'b0;
        check("mr cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("mr valid", 32'(beat_valid), 32'd0);
        check("mr addr", beat_addr, 32'd0);
        check("mr idx", 32'(beat_idx), 32'd0);
        check("mr id", 32'(beat_id), 32'd0);
        check("mr busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr after valid", 32'(beat_valid), 32'd0);
        check("mr after ready", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
